// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision operand unpacker.
// Class codes are visible on the output ports, so their encodings are fixed.
package fp_pkg;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_class_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_NORM_A = 2'd1,
      ST_NORM_B = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam int FRAC_W   = 23;
   localparam int MAN_W    = 24;

   function automatic fp_class_t classify(input logic [31:0] op);
      logic [7:0]        e;
      logic [FRAC_W-1:0] f;
      e = op[30:23];
      f = op[FRAC_W-1:0];
      if (e == 8'd0)
         classify = (f == '0) ? CLS_ZERO : CLS_SUB;
      else if (e != 8'(EXP_MAX))
         classify = CLS_NORM;
      else if (f == '0)
         classify = CLS_INF;
      else
         classify = f[FRAC_W-1] ? CLS_QNAN : CLS_SNAN;
   endfunction

endpackage

// File: rtl/fp_unpack_lane.sv
// One operand lane: decodes on load, then left-shifts a subnormal mantissa
// one bit per step while decrementing the exponent.
module fp_unpack_lane
   import fp_pkg::*;
#(
   parameter int EXP_W = 10
) (
   input  logic                clk,
   input  logic                arst,
   input  logic                load_i,
   input  logic                step_i,
   input  logic [31:0]         op_i,
   output logic                in_is_sub_o,
   output logic                sign_o,
   output logic [EXP_W-1:0]    exp_o,
   output logic [MAN_W-1:0]    man_o,
   output fp_class_t           cls_o,
   output logic                norm_done_o
);

   fp_class_t         cls_in;
   logic              sign_q, sign_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [MAN_W-1:0]  man_q, man_d;
   fp_class_t         cls_q, cls_d;

   assign cls_in      = classify(op_i);
   assign in_is_sub_o = (cls_in == CLS_SUB);

   always_comb begin
      sign_d = sign_q;
      exp_d  = exp_q;
      man_d  = man_q;
      cls_d  = cls_q;
      if (load_i) begin
         sign_d = op_i[31];
         cls_d  = cls_in;
         case (cls_in)
            CLS_ZERO: begin
               man_d = '0;
               exp_d = '0;
            end
            CLS_SUB: begin
               // Subnormals start from the minimum normal exponent, then get shifted.
               man_d = {1'b0, op_i[FRAC_W-1:0]};
               exp_d = EXP_W'(1);
            end
            CLS_NORM: begin
               man_d = {1'b1, op_i[FRAC_W-1:0]};
               exp_d = EXP_W'(op_i[30:23]);
            end
            default: begin
               man_d = {1'b0, op_i[FRAC_W-1:0]};
               exp_d = EXP_W'(EXP_MAX);
            end
         endcase
      end else if (step_i) begin
         man_d = {man_q[MAN_W-2:0], 1'b0};
         exp_d = exp_q - EXP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sign_q <= 1'b0;
         exp_q  <= '0;
         man_q  <= '0;
         cls_q  <= CLS_ZERO;
      end else begin
         sign_q <= sign_d;
         exp_q  <= exp_d;
         man_q  <= man_d;
         cls_q  <= cls_d;
      end
   end

   assign sign_o      = sign_q;
   assign exp_o       = exp_q;
   assign man_o       = man_q;
   assign cls_o       = cls_q;
   assign norm_done_o = man_q[MAN_W-2];

endmodule

// File: rtl/fp_unpacker.sv
// Operand unpacker for the multiply/divide datapath: handshake, sequencing FSM
// and two decode lanes. Subnormals are normalized a before b, one bit per cycle.
module fp_unpacker
   import fp_pkg::*;
#(
   parameter int EXP_W = 10
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   input  logic              sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sign_a,
   output logic              sign_b,
   output logic [EXP_W-1:0]  exp_a,
   output logic [EXP_W-1:0]  exp_b,
   output logic [MAN_W-1:0]  man_a,
   output logic [MAN_W-1:0]  man_b,
   output logic [2:0]        class_a,
   output logic [2:0]        class_b,
   output logic              sel_out
);

   state_t    state_q;
   logic      out_valid_q;
   logic      sel_q;
   logic      accept;
   logic      in_sub_a, in_sub_b;
   logic      done_a, done_b;
   fp_class_t cls_a, cls_b;

   assign in_ready = (state_q == ST_IDLE) & en;
   assign accept   = in_valid & in_ready;

   fp_unpack_lane #(.EXP_W(EXP_W)) u_lane_a (
      .clk         (clk),
      .arst        (arst),
      .load_i      (accept),
      .step_i      (en & (state_q == ST_NORM_A)),
      .op_i        (op_a),
      .in_is_sub_o (in_sub_a),
      .sign_o      (sign_a),
      .exp_o       (exp_a),
      .man_o       (man_a),
      .cls_o       (cls_a),
      .norm_done_o (done_a)
   );

   fp_unpack_lane #(.EXP_W(EXP_W)) u_lane_b (
      .clk         (clk),
      .arst        (arst),
      .load_i      (accept),
      .step_i      (en & (state_q == ST_NORM_B)),
      .op_i        (op_b),
      .in_is_sub_o (in_sub_b),
      .sign_o      (sign_b),
      .exp_o       (exp_b),
      .man_o       (man_b),
      .cls_o       (cls_b),
      .norm_done_o (done_b)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         sel_q       <= 1'b0;
      end else if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  sel_q <= sel;
                  if (in_sub_a) begin
                     state_q <= ST_NORM_A;
                  end else if (in_sub_b) begin
                     state_q <= ST_NORM_B;
                  end else begin
                     state_q     <= ST_HOLD;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_NORM_A: begin
               // done reflects the pre-shift bit 22, so this is the last shift.
               if (done_a) begin
                  if (cls_b == CLS_SUB) begin
                     state_q <= ST_NORM_B;
                  end else begin
                     state_q     <= ST_HOLD;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_NORM_B: begin
               if (done_b) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign sel_out   = sel_q;
   assign class_a   = cls_a;
   assign class_b   = cls_b;

endmodule

// File: tb/tb_fp_unpacker.sv
// Directed bench for fp_unpacker: expected results are queued at stimulus time
// and popped when out_valid is seen, together with the measured latency.
module tb_fp_unpacker;

   logic        clk = 1'b0;
   logic        arst, en, in_valid, in_ready, sel, out_valid, out_ready;
   logic [31:0] op_a, op_b;
   logic        sign_a, sign_b, sel_out;
   logic [9:0]  exp_a, exp_b;
   logic [23:0] man_a, man_b;
   logic [2:0]  class_a, class_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic [23:0] m;
      logic [2:0]  c;
      int          k;
   } lane_exp_t;

   typedef struct {
      lane_exp_t a;
      lane_exp_t b;
      logic      sel;
      int        lat;
   } exp_t;

   exp_t sb_q[$];

   fp_unpacker #(.EXP_W(10)) dut (
      .clk       (clk),
      .arst      (arst),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .exp_a     (exp_a),
      .exp_b     (exp_b),
      .man_a     (man_a),
      .man_b     (man_b),
      .class_a   (class_a),
      .class_b   (class_b),
      .sel_out   (sel_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference decode: count leading zeros of {0,f} to normalize subnormals.
   function automatic lane_exp_t model(input logic [31:0] op);
      lane_exp_t   r;
      logic [7:0]  e;
      logic [22:0] f;
      logic [23:0] m;
      int          k;
      e   = op[30:23];
      f   = op[22:0];
      k   = 0;
      r.s = op[31];
      r.k = 0;
      if (e == 8'd0 && f == 23'd0) begin
         r.c = 3'd0; r.m = 24'd0; r.e = 10'd0;
      end else if (e == 8'd0) begin
         m = {1'b0, f};
         while (!m[23]) begin
            m = m << 1;
            k++;
         end
         r.c = 3'd1; r.m = m; r.e = 10'(1 - k); r.k = k;
      end else if (e == 8'hFF) begin
         r.m = {1'b0, f};
         r.e = 10'd255;
         r.c = (f == 23'd0) ? 3'd3 : (f[22] ? 3'd4 : 3'd5);
      end else begin
         r.c = 3'd2; r.m = {1'b1, f}; r.e = {2'b00, e};
      end
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge after HOLD->IDLE.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int stall_at, input int bp);
      exp_t x, y;
      int   n;
      x.a   = model(a);
      x.b   = model(b);
      x.sel = s;
      x.lat = 1 + x.a.k + x.b.k + ((stall_at > 0) ? 3 : 0);
      sb_q.push_back(x);

      op_a = a; op_b = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (bp == 0) begin
            in_valid = 1'b0;
         end else begin
            op_a = 32'h3F7FFFFF; op_b = 32'hC0490FDB; sel = ~s;
         end
         if (stall_at > 0 && n == stall_at)     en = 1'b0;
         if (stall_at > 0 && n == stall_at + 3) en = 1'b1;
      end while (!out_valid && n < 200);
      en = 1'b1;
      if (!out_valid) chk("timeout", 0, 1);

      y = sb_q.pop_front();
      chk("latency", n, y.lat);
      chk("sign_a",  sign_a,  y.a.s);
      chk("sign_b",  sign_b,  y.b.s);
      chk("exp_a",   exp_a,   y.a.e);
      chk("exp_b",   exp_b,   y.b.e);
      chk("man_a",   man_a,   y.a.m);
      chk("man_b",   man_b,   y.b.m);
      chk("class_a", class_a, y.a.c);
      chk("class_b", class_b, y.b.c);
      chk("sel_out", sel_out, y.sel);

      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_valid",    out_valid, 1);
         chk("bp_in_ready", in_ready,  0);
         chk("bp_man_a",    man_a,     y.a.m);
         chk("bp_exp_b",    exp_b,     y.b.e);
         chk("bp_sel_out",  sel_out,   y.sel);
      end

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_clear", out_valid, 0);
      chk("in_ready_ret", in_ready, 1);
      $display("op a=%h b=%h sel=%0d latency=%0d exp_a=%h exp_b=%h man_a=%h man_b=%h cls=%0d/%0d",
               a, b, s, n, exp_a, exp_b, man_a, man_b, class_a, class_b);
   endtask

   initial begin
      arst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = 32'd0; op_b = 32'd0; sel = 1'b0;
      repeat (3) @(negedge clk);
      arst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_man_a",     man_a,     0);
      chk("rst_exp_b",     exp_b,     0);
      chk("rst_class_a",   class_a,   0);
      chk("rst_sel_out",   sel_out,   0);
      chk("rst_in_ready",  in_ready,  1);
      @(negedge clk);

      run_op(32'h3FC00000, 32'h40000000, 1'b0, 0, 0);
      run_op(32'h00000001, 32'h3F800000, 1'b1, 0, 0);
      run_op(32'h00400000, 32'h00200000, 1'b0, 0, 0);
      run_op(32'h80000000, 32'h7F800000, 1'b1, 0, 0);
      run_op(32'h7FC00000, 32'h7F800001, 1'b0, 0, 0);
      run_op(32'h80000003, 32'h00000001, 1'b1, 0, 0);
      run_op(32'h3F800000, 32'h807FFFFF, 1'b0, 0, 0);

      // Backpressure with in_valid held high; the next pair goes in right after.
      run_op(32'h40490FDB, 32'h00000010, 1'b1, 0, 5);
      run_op(32'hC2280000, 32'h3E800000, 1'b0, 0, 0);

      // en dropped for three cycles while lane a is shifting.
      run_op(32'h00000001, 32'h3F800000, 1'b0, 5, 0);

      // Reset in the middle of NORM_A.
      op_a = 32'h00000001; op_b = 32'hBF800000; sel = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      arst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_man_a",     man_a,     0);
      chk("mid_rst_exp_a",     exp_a,     0);
      chk("mid_rst_sign_b",    sign_b,    0);
      chk("mid_rst_class_a",   class_a,   0);
      chk("mid_rst_sel_out",   sel_out,   0);
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready",  in_ready,  1);
      chk("mid_rst_idle_valid", out_valid, 0);

      run_op(32'h3FC00000, 32'h00000002, 1'b1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_unpacker.md
# fp_unpacker

Front-end operand unpacker for the single-precision multiply/divide datapath: the inverse of the output-side normalizer. Accepts two IEEE 754 single-precision operands with a valid/ready handshake. For each operand it separates the sign, exponent and fraction, and restores the hidden bit. Subnormal operands are pre-normalized by an iterative 1-bit/cycle left-shift FSM, so the downstream multiplier and divider always receive 24-bit mantissas with bit 23 set, or a flagged special value.

## Interface
- `EXP_W`, default 10: width of the output exponent, two's complement, biased by 127. Matches the 10-bit exponent path.
- `clk` in 1: clock, rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `en` in 1: global enable. While low, all state freezes and no handshake completes.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: equals `(state==IDLE) & en`, combinational.
- `op_a`, `op_b` in 32 each: IEEE 754 single operands.
- `sel` in 1: operation select, 0 = mul, 1 = div. Captured on accept.
- `out_valid` out 1: unpacked result valid, registered.
- `out_ready` in 1: downstream accepts the result.
- `sign_a`, `sign_b` out 1 each: operand signs.
- `exp_a`, `exp_b` out `EXP_W` each: effective biased exponents.
- `man_a`, `man_b` out 24 each: mantissas including the hidden bit.
- `class_a`, `class_b` out 3 each: operand class.
- `sel_out` out 1: captured `sel`.

## Operation
- **Class codes:** ZERO=0, SUB=1, NORM=2, INF=3, QNAN=4, SNAN=5.
- **Decode on accept** (`in_valid & in_ready`), for each operand with e = [30:23] and f = [22:0]:
  - e=0, f=0 → ZERO; man=0, exp=0.
  - e=0, f≠0 → SUB; man={0,f}, exp=1, then normalized.
  - 0<e<255 → NORM; man={1,f}, exp=e.
  - e=255, f=0 → INF; man={0,f}, exp=255.
  - e=255, f[22]=1 → QNAN; man={0,f}, exp=255.
  - e=255, f[22]=0, f≠0 → SNAN; man={0,f}, exp=255.
  - The sign is always bit 31.
- **FSM states:** IDLE, NORM_A, NORM_B, HOLD.
  - IDLE, on accept: go to NORM_A if a is SUB, else NORM_B if b is SUB, else HOLD.
  - NORM_x, each en cycle: man_x <= man_x<<1; exp_x <= exp_x−1. If pre-shift man_x[22]=1, leave after this cycle: NORM_A goes to NORM_B if b is SUB, else HOLD. NORM_B goes to HOLD.
  - HOLD: `out_valid`=1. When `out_ready & en`, go to IDLE and clear `out_valid`.
- **Shift count:** k = number of leading zeros of {0,f} in 24 bits, range 1..23. NORM_x occupies exactly k cycles.
- **Final subnormal exponent:** 1−k, range 0 to −22, in two's complement `EXP_W` bits. `class_x` remains SUB after normalization.
- **Output stability:** data outputs change only on accept or during NORM. They are stable throughout HOLD.
- **No overlap:** no new operand is accepted until the HOLD→IDLE handshake completes.

## Timing
- **Reset:** all outputs 0 and state IDLE. `in_ready` becomes 1 once arst deasserts and en=1.
- **Reset mid-operation:** arst asserted in any state aborts the operation. The in-flight operand is discarded, with no partial output.
- **Latency:** accept at edge T; `out_valid` rises at T+1+k_a+k_b, where k=0 for a non-SUB operand.
  - Both operands normal or special: 1 cycle.
  - Worst case, both operands with f=1: 47 cycles.
- **en low:** counts as no cycle. The shift does not advance and neither handshake completes. `out_valid` and the data outputs hold their values.
- **Simultaneous events:** in_valid is ignored outside IDLE. `out_ready` is ignored outside HOLD.
- **Minimum throughput:** one result per 2 cycles, because the HOLD→IDLE handshake precedes the next accept.

## Structure
- **Package `fp_pkg`:**
  - class enum (`fp_class_t`, 3 bits).
  - state enum.
  - constants: `EXP_BIAS`=127, `EXP_MAX`=255, `FRAC_W`=23, `MAN_W`=24.
- **Sub-module `fp_unpack_lane`:** one instance per operand.
  - Holds the decode plus the sign/exp/man/class registers and the 1-bit shifter.
  - Inputs: `load`, `step`. Output: `norm_done`, defined as man[22] pre-shift.
  - The top level holds the FSM and the handshake.

## Test plan
1. **Normal operands:** a=0x3FC00000, b=0x40000000, accepted at T → at T+1: man_a=0xC00000, exp_a=127, man_b=0x800000, exp_b=128, both NORM, signs 0.
2. **Deepest subnormal:** a=0x00000001, b=0x3F800000 → 23 NORM_A cycles; `out_valid` at T+24; man_a=0x800000, exp_a=0x3EA (−22), class SUB.
3. **Two subnormals:** a=0x00400000, b=0x00200000 → k_a=1, k_b=2; `out_valid` at T+4; exp_a=0x000, exp_b=0x3FF, man_a=man_b=0x800000.
4. **Specials:**
   - 0x80000000 → ZERO, sign 1.
   - 0x7F800000 → INF.
   - 0x7FC00000 → QNAN.
   - 0x7F800001 → SNAN.
   - In all cases exp=255, or 0 for ZERO, and latency is 1.
5. **Backpressure:** out_ready=0 for 5 cycles with in_valid held high → outputs stable, `in_ready`=0, no second accept. After out_ready=1, back to IDLE, and the next pair is accepted on the following cycle.
6. **Stall and reset:**
   - en=0 for 3 cycles during NORM_A of a=0x00000001 → latency extends to T+27, result unchanged.
   - arst pulsed mid-NORM_A → all outputs 0, IDLE, `in_ready`=1 after release.
